// File: rtl/system_parameters.sv
// Shared widths and types for the quantizer front-end.
//   INPUT_DATA_BITWIDTH   : packed Q[31:16], I[15:0] scaled sample width
//   QUANTISATION_BITWIDTH : output width of the downstream quantizer
//   sched_state_t         : frame scheduler FSM states
package system_parameters;

    localparam int INPUT_DATA_BITWIDTH   = 32;
    localparam int QUANTISATION_BITWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARB    = 2'd1,
        STREAM = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational.
//   req[1:0]  : request per channel (bit 0 = ch0, bit 1 = ch1)
//   lastGrant : channel granted most recently (0 = ch0, 1 = ch1)
//   grant[1:0]: one-hot grant, all-zero when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Contention: hand the bus to whoever did not have it last.
            2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/quant_frame_sched.sv
// Frame scheduler between two sample channels and the quantizer.
// Picks a channel round-robin, then streams exactly one frame of
// frameLen samples from it through a single output register.
//
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   enable                : allows new frames to start
//   frameLen              : samples per frame, latched at grant (0 -> 1)
//   ch0Data/ch1Data       : packed Q/I samples
//   ch0Valid/ch1Valid     : sample present on channel
//   ch0Ready/ch1Ready     : channel sample accepted on Valid & Ready
//   scaledData, inValid   : registered sample to the quantizer
//   outReady              : downstream accepts on inValid & outReady
//   chanId, sof, eof      : sample attributes, qualified by inValid
//   busy                  : FSM not in IDLE
//   frameCount            : frames delivered downstream (wraps)
//   debugState            : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; a source holds valid and data stable until that edge,
// and ready never depends combinationally on the same side's valid.
module quant_frame_sched
    import system_parameters::*;
#(
    parameter int FRAME_LEN_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [FRAME_LEN_W-1:0]         frameLen,
    input  logic [INPUT_DATA_BITWIDTH-1:0] ch0Data,
    input  logic [INPUT_DATA_BITWIDTH-1:0] ch1Data,
    input  logic                           ch0Valid,
    input  logic                           ch1Valid,
    output logic                           ch0Ready,
    output logic                           ch1Ready,
    output logic [INPUT_DATA_BITWIDTH-1:0] scaledData,
    output logic                           inValid,
    input  logic                           outReady,
    output logic                           chanId,
    output logic                           sof,
    output logic                           eof,
    output logic                           busy,
    output logic [FRAME_LEN_W-1:0]         frameCount,
    output sched_state_t                   debugState
);

    localparam logic [FRAME_LEN_W-1:0] LEN_ONE = FRAME_LEN_W'(1);

    sched_state_t             state_q, state_d;
    logic                     sel_q;     // channel owning the current frame
    logic                     last_q;    // channel granted most recently
    logic [FRAME_LEN_W-1:0]   len_q;
    logic [FRAME_LEN_W-1:0]   cnt_q;

    logic [1:0]               req;
    logic [1:0]               arb_grant;
    logic                     can_load;
    logic                     sel_valid;
    logic [INPUT_DATA_BITWIDTH-1:0] sel_data;
    logic                     is_last;
    logic                     accept;

    assign req       = {ch1Valid, ch0Valid};
    // Output register can take a new sample if empty or being drained now.
    assign can_load  = !inValid || outReady;
    assign sel_valid = sel_q ? ch1Valid : ch0Valid;
    assign sel_data  = sel_q ? ch1Data  : ch0Data;
    assign is_last   = (cnt_q == len_q - LEN_ONE);

    assign busy       = (state_q != IDLE);
    assign debugState = state_q;

    rr_arb2 u_rr_arb2 (
        .req       (req),
        .lastGrant (last_q),
        .grant     (arb_grant)
    );

    always_comb begin
        state_d  = state_q;
        ch0Ready = 1'b0;
        ch1Ready = 1'b0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (|req)) state_d = ARB;
            end
            ARB: begin
                // Requester may have withdrawn since IDLE; fall back then.
                state_d = (|arb_grant) ? STREAM : IDLE;
            end
            STREAM: begin
                ch0Ready = !sel_q && can_load;
                ch1Ready =  sel_q && can_load;
                accept   = sel_valid && can_load;
                // enable only matters at frame boundaries, never mid-frame.
                if (accept && is_last) begin
                    state_d = (enable && (|req)) ? ARB : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;  // first contended grant goes to ch0
            len_q      <= LEN_ONE;
            cnt_q      <= '0;
            scaledData <= '0;
            inValid    <= 1'b0;
            chanId     <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frameCount <= '0;
        end else begin
            state_q <= state_d;

            if (state_q == ARB) begin
                len_q <= (frameLen == '0) ? LEN_ONE : frameLen;
                cnt_q <= '0;
                if (|arb_grant) begin
                    sel_q  <= arb_grant[1];
                    last_q <= arb_grant[1];
                end
            end

            if (accept) begin
                cnt_q      <= is_last ? '0 : cnt_q + LEN_ONE;
                scaledData <= sel_data;
                inValid    <= 1'b1;
                chanId     <= sel_q;
                sof        <= (cnt_q == '0);
                eof        <= is_last;
            end else if (outReady) begin
                inValid    <= 1'b0;
            end

            if (inValid && outReady && eof) begin
                frameCount <= frameCount + LEN_ONE;
            end
        end
    end

endmodule

// File: tb/tb_quant_frame_sched.sv
`timescale 1ns/1ps
module tb_quant_frame_sched;
    import system_parameters::*;

    // Narrow frame counter keeps the wrap-around scenario short.
    localparam int FLW = 8;
    localparam int DW  = INPUT_DATA_BITWIDTH;
    localparam int EW  = DW + 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           enable   = 1'b0;
    logic [FLW-1:0] frameLen = '0;
    logic [DW-1:0]  ch0Data  = '0;
    logic [DW-1:0]  ch1Data  = '0;
    logic           ch0Valid = 1'b0;
    logic           ch1Valid = 1'b0;
    logic           outReady = 1'b1;
    logic           ch0Ready, ch1Ready, inValid, chanId, sof, eof, busy;
    logic [DW-1:0]  scaledData;
    logic [FLW-1:0] frameCount;
    sched_state_t   debugState;

    quant_frame_sched #(.FRAME_LEN_W(FLW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .frameLen   (frameLen),
        .ch0Data    (ch0Data),
        .ch1Data    (ch1Data),
        .ch0Valid   (ch0Valid),
        .ch1Valid   (ch1Valid),
        .ch0Ready   (ch0Ready),
        .ch1Ready   (ch1Ready),
        .scaledData (scaledData),
        .inValid    (inValid),
        .outReady   (outReady),
        .chanId     (chanId),
        .sof        (sof),
        .eof        (eof),
        .busy       (busy),
        .frameCount (frameCount),
        .debugState (debugState)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    logic [DW-1:0] src0_q[$];
    logic [DW-1:0] src1_q[$];
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int hi, input int lo);
        return {16'(hi), 16'(lo)};
    endfunction

    function automatic void exp_push(input logic [DW-1:0] d, input logic c, input logic s, input logic e);
        exp_q.push_back({d, c, s, e});
    endfunction

    // ---------------- channel source drivers ----------------
    logic          f0 = 1'b0;
    logic          f1 = 1'b0;
    logic          lat_pend = 1'b0;
    logic [DW-1:0] lat_data = '0;

    always begin
        @(posedge clk);
        if (f0 && src0_q.size() > 0) void'(src0_q.pop_front());
        if (f1 && src1_q.size() > 0) void'(src1_q.pop_front());
        #2;
        ch0Valid = (src0_q.size() > 0);
        ch0Data  = ch0Valid ? src0_q[0] : '0;
        ch1Valid = (src1_q.size() > 0);
        ch1Data  = ch1Valid ? src1_q[0] : '0;
    end

    // Input-side checks: 1-cycle latency, ready gating, ready exclusivity.
    always @(negedge clk) begin
        if (!rst || !armed) begin
            lat_pend = 1'b0;
            f0 = 1'b0;
            f1 = 1'b0;
        end else begin
            if (lat_pend) begin
                check("lat_valid", 64'(inValid), 64'(1'b1));
                check("lat_data", 64'(scaledData), 64'(lat_data));
            end
            if (inValid && !outReady)
                check("rdy_stall", 64'({ch1Ready, ch0Ready}), 64'(2'b00));
            check("rdy_excl", 64'(ch0Ready & ch1Ready), 64'(1'b0));
            f0 = ch0Valid && ch0Ready;
            f1 = ch1Valid && ch1Ready;
            lat_pend = f0 || f1;
            lat_data = f0 ? ch0Data : ch1Data;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic          hold_pend = 1'b0;
    logic [EW-1:0] hold_val  = '0;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst || !armed) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(inValid), 64'(1'b1));
                check("hold_out", 64'({scaledData, chanId, sof, eof}), 64'(hold_val));
            end
            hold_pend = inValid && !outReady;
            hold_val  = {scaledData, chanId, sof, eof};
            if (inValid && outReady) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got 0x%0h, expected no output", {scaledData, chanId, sof, eof});
                end else begin
                    e = exp_q.pop_front();
                    check("out", 64'({scaledData, chanId, sof, eof}), 64'(e));
                end
            end
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic reset_assert();
        @(posedge clk);
        #2;
        rst = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_inValid", 64'(inValid), 64'(1'b0));
        check("rst_data", 64'(scaledData), 64'(0));
        check("rst_flags", 64'({chanId, sof, eof}), 64'(3'b000));
        check("rst_ready", 64'({ch1Ready, ch0Ready}), 64'(2'b00));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_count", 64'(frameCount), 64'(0));
        check("rst_state", 64'(debugState), 64'(IDLE));
    endtask

    task automatic wait_size(input int n, input int budget, input string name);
        int k = 0;
        while (exp_q.size() > n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() > n) begin
            errors++;
            $display("FAIL %s: %0d outputs outstanding, expected at most %0d", name, exp_q.size(), n);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset_assert();
        armed = 1'b1;

        // 1: single channel, frameLen=4
        @(posedge clk); #2;
        rst = 1'b1;
        frameLen = 8'd4;
        enable = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            src0_q.push_back(mk(i, i));
            exp_push(mk(i, i), 1'b0, i == 1, i == 4);
        end
        wait_size(0, 100, "t1_drain");
        settle();
        check("t1_count", 64'(frameCount), 64'(1));
        check("t1_busy", 64'(busy), 64'(1'b0));

        // 2: both channels, frameLen=2, round robin from ch0
        reset_assert();
        @(posedge clk); #2;
        rst = 1'b1;
        frameLen = 8'd2;
        enable = 1'b1;
        src0_q.push_back(mk(16'hA, 1));
        src0_q.push_back(mk(16'hA, 2));
        src0_q.push_back(mk(16'hA, 3));
        src0_q.push_back(mk(16'hA, 4));
        src1_q.push_back(mk(16'hB, 1));
        src1_q.push_back(mk(16'hB, 2));
        exp_push(mk(16'hA, 1), 1'b0, 1'b1, 1'b0);
        exp_push(mk(16'hA, 2), 1'b0, 1'b0, 1'b1);
        exp_push(mk(16'hB, 1), 1'b1, 1'b1, 1'b0);
        exp_push(mk(16'hB, 2), 1'b1, 1'b0, 1'b1);
        exp_push(mk(16'hA, 3), 1'b0, 1'b1, 1'b0);
        exp_push(mk(16'hA, 4), 1'b0, 1'b0, 1'b1);
        wait_size(0, 100, "t2_drain");
        settle();
        check("t2_count", 64'(frameCount), 64'(3));

        // 3: downstream stall for 3 cycles mid-frame
        @(posedge clk); #2;
        frameLen = 8'd4;
        for (int i = 1; i <= 4; i++) begin
            src0_q.push_back(mk(16'hC, i));
            exp_push(mk(16'hC, i), 1'b0, i == 1, i == 4);
        end
        wait_size(2, 100, "t3_mid");
        @(posedge clk); #2;
        outReady = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        outReady = 1'b1;
        wait_size(0, 100, "t3_drain");
        settle();
        check("t3_count", 64'(frameCount), 64'(4));

        // 4: enable dropped mid-frame, frameLen=5 still completes
        @(posedge clk); #2;
        frameLen = 8'd5;
        for (int i = 1; i <= 8; i++) begin
            src0_q.push_back(mk(16'hD, i));
            if (i <= 5) exp_push(mk(16'hD, i), 1'b0, i == 1, i == 5);
        end
        wait_size(3, 100, "t4_mid");
        @(posedge clk); #2;
        enable = 1'b0;
        wait_size(0, 100, "t4_drain");
        repeat (6) @(negedge clk);
        check("t4_busy", 64'(busy), 64'(1'b0));
        check("t4_state", 64'(debugState), 64'(IDLE));
        check("t4_count", 64'(frameCount), 64'(5));
        @(posedge clk); #2;
        src0_q.delete();

        // 5: reset mid-frame, then contended grant must go to ch0
        @(posedge clk); #2;
        frameLen = 8'd8;
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            src0_q.push_back(mk(16'hE, i));
            exp_push(mk(16'hE, i), 1'b0, i == 1, i == 8);
        end
        wait_size(5, 100, "t5_mid");
        reset_assert();
        @(posedge clk); #2;
        frameLen = 8'd2;
        src0_q.push_back(mk(16'hF0, 1));
        src0_q.push_back(mk(16'hF0, 2));
        src1_q.push_back(mk(16'hF1, 1));
        src1_q.push_back(mk(16'hF1, 2));
        exp_push(mk(16'hF0, 1), 1'b0, 1'b1, 1'b0);
        exp_push(mk(16'hF0, 2), 1'b0, 1'b0, 1'b1);
        exp_push(mk(16'hF1, 1), 1'b1, 1'b1, 1'b0);
        exp_push(mk(16'hF1, 2), 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        wait_size(0, 100, "t5_drain");
        settle();
        check("t5_count", 64'(frameCount), 64'(2));

        // 6: frameLen=0 -> one-sample frames; frameCount reaches max then wraps
        reset_assert();
        @(posedge clk); #2;
        rst = 1'b1;
        frameLen = '0;
        enable = 1'b1;
        for (int i = 0; i < 255; i++) begin
            src1_q.push_back(mk(16'h55, i));
            exp_push(mk(16'h55, i), 1'b1, 1'b1, 1'b1);
        end
        wait_size(0, 2000, "t6_drain");
        settle();
        check("t6_max", 64'(frameCount), 64'(8'hFF));
        @(posedge clk); #2;
        src1_q.push_back(mk(16'h66, 1));
        exp_push(mk(16'h66, 1), 1'b1, 1'b1, 1'b1);
        wait_size(0, 100, "t6_last");
        settle();
        check("t6_wrap", 64'(frameCount), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
